// File: rtl/sat_clause_sequencer.sv
// CNF initiator: streams stored literal beats into the clause/CNF evaluator and reports SAT/UNSAT.
// Optional macro SAT_SEQ_EARLY_EXIT_EN: stop after the first false clause.
module sat_clause_sequencer #(
    parameter int DEPTH = 64,
    parameter int NLIT  = 6,
    parameter int VW    = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int EW   = 1 + NLIT + NLIT * VW
) (
    input  logic               clk,
    input  logic               resetClause,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [EW-1:0]      wr_data,
    input  logic [AW:0]        num_entries,
    input  logic               start,
    output logic [NLIT-1:0]    negCtrl,
    output logic [NLIT*VW-1:0] varPos,
    output logic               enableClause,
    output logic               clause_clr_n,
    output logic               enableCNF,
    output logic               cnf_clr_n,
    input  logic               outCNF,
    output logic               busy,
    output logic               done,
    output logic               sat,
    output logic [2:0]         o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_ACC   = 3'd3,
        S_CLR   = 3'd4,
        S_FIN   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t          r_state;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW:0]     r_ptr;
    logic [AW:0]     r_n;
    logic            r_last;
    logic [EW-1:0]   w_entry;
    logic            w_clause_end;
    logic            w_stop;

    assign o_dbg_state  = r_state;
    assign w_entry      = r_mem[r_ptr[AW-1:0]];
    // r_ptr already points past the beat being driven, so ptr==N means this is the final entry.
    assign w_clause_end = r_last || (r_ptr == r_n);
`ifdef SAT_SEQ_EARLY_EXIT_EN
    assign w_stop       = (r_ptr == r_n) || !outCNF;
`else
    assign w_stop       = (r_ptr == r_n);
`endif

    // Entry memory is not reset; writes are only accepted while idle.
    always_ff @(posedge clk) begin
        if (wr_en && (r_state == S_IDLE))
            r_mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge resetClause) begin
        if (!resetClause) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_n          <= '0;
            r_last       <= 1'b0;
            negCtrl      <= '0;
            varPos       <= '0;
            enableClause <= 1'b0;
            enableCNF    <= 1'b0;
            clause_clr_n <= 1'b0;
            cnf_clr_n    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sat          <= 1'b0;
        end else begin
            // Outputs are registered for the state being entered; defaults are the quiet values.
            enableClause <= 1'b0;
            enableCNF    <= 1'b0;
            clause_clr_n <= 1'b1;
            cnf_clr_n    <= 1'b1;
            done         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n          <= num_entries;
                        r_ptr        <= '0;
                        busy         <= 1'b1;
                        sat          <= 1'b0;
                        clause_clr_n <= 1'b0;
                        cnf_clr_n    <= 1'b0;
                        r_state      <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (r_n == '0) begin
                        r_state <= S_FIN;
                    end else begin
                        negCtrl      <= w_entry[EW-2 -: NLIT];
                        varPos       <= w_entry[NLIT*VW-1:0];
                        r_last       <= w_entry[EW-1];
                        r_ptr        <= r_ptr + 1'b1;
                        enableClause <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_clause_end) begin
                        enableCNF <= 1'b1;
                        r_state   <= S_ACC;
                    end else begin
                        negCtrl      <= w_entry[EW-2 -: NLIT];
                        varPos       <= w_entry[NLIT*VW-1:0];
                        r_last       <= w_entry[EW-1];
                        r_ptr        <= r_ptr + 1'b1;
                        enableClause <= 1'b1;
                    end
                end
                S_ACC: begin
                    clause_clr_n <= 1'b0;
                    r_state      <= S_CLR;
                end
                S_CLR: begin
                    if (w_stop) begin
                        r_state <= S_FIN;
                    end else begin
                        negCtrl      <= w_entry[EW-2 -: NLIT];
                        varPos       <= w_entry[NLIT*VW-1:0];
                        r_last       <= w_entry[EW-1];
                        r_ptr        <= r_ptr + 1'b1;
                        enableClause <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_FIN: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    sat     <= outCNF;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sat_clause_sequencer.sv
// Directed bench for sat_clause_sequencer with a behavioural clause/CNF evaluator (truth 16'h0006).
module tb_sat_clause_sequencer;

    logic        clk;
    logic        resetClause;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [30:0] wr_data;
    logic [6:0]  num_entries;
    logic        start;
    logic [5:0]  negCtrl;
    logic [23:0] varPos;
    logic        enableClause;
    logic        clause_clr_n;
    logic        enableCNF;
    logic        cnf_clr_n;
    logic        outCNF;
    logic        busy;
    logic        done;
    logic        sat;
    logic [2:0]  o_dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;
    int viol     = 0;

    sat_clause_sequencer dut (
        .clk(clk), .resetClause(resetClause), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .num_entries(num_entries), .start(start), .negCtrl(negCtrl),
        .varPos(varPos), .enableClause(enableClause), .clause_clr_n(clause_clr_n),
        .enableCNF(enableCNF), .cnf_clr_n(cnf_clr_n), .outCNF(outCNF), .busy(busy),
        .done(done), .sat(sat), .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // evaluator model: x1 = x2 = 1, all other variables 0
    logic [15:0] truth;
    logic        r_clause;
    logic        r_cnf;
    logic        w_lit_or;
    assign truth  = 16'h0006;
    assign outCNF = r_cnf;
    always_comb begin
        w_lit_or = 1'b0;
        for (int k = 0; k < 6; k++)
            w_lit_or = w_lit_or | (truth[varPos[4*k +: 4]] ^ negCtrl[k]);
    end
    always @(posedge clk) begin
        if (!clause_clr_n)     r_clause <= 1'b0;
        else if (enableClause) r_clause <= r_clause | w_lit_or;
        if (!cnf_clr_n)        r_cnf <= 1'b1;
        else if (enableCNF)    r_cnf <= r_cnf & r_clause;
    end

    always @(negedge clk) begin
        if (enableCNF) acc_cnt++;
        if (done) done_cnt++;
        if ((enableClause && !clause_clr_n) || (enableCNF && !cnf_clr_n)) viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [30:0] ent1(input logic last, input logic neg, input logic [3:0] v);
        return {last, {6{neg}}, v, v, v, v, v, v};
    endfunction

    // driver tasks
    task automatic write_entry(input logic [5:0] a, input logic [30:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic run(input logic [6:0] n, input int exp_lat, input logic exp_sat,
                       input int exp_acc, input logic inject, input string tag);
        int cyc;
        @(negedge clk);
        num_entries = n; start = 1'b1; acc_cnt = 0; done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!done && cyc < 200) begin
            if (inject && cyc == 3) begin
                wr_en = 1'b1; wr_addr = 6'd0; wr_data = ent1(1'b1, 1'b0, 4'd0);
                start = 1'b1; num_entries = 7'd2;
            end else begin
                wr_en = 1'b0; start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        wr_en = 1'b0; start = 1'b0;
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_sat"}, 32'(sat), 32'(exp_sat));
        check({tag, "_idle"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_sat_hold"}, 32'(sat), 32'(exp_sat));
        repeat (12) @(posedge clk);
        #1;
        check({tag, "_acc"}, 32'(acc_cnt), 32'(exp_acc));
        check({tag, "_ndone"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        resetClause = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        num_entries = '0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_en", {30'd0, enableClause, enableCNF}, 32'd0);
        check("rst_clr", {30'd0, clause_clr_n, cnf_clr_n}, 32'd0);
        check("rst_lits", {2'd0, negCtrl, varPos}, 32'd0);
        @(negedge clk); resetClause = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_clr", {30'd0, clause_clr_n, cnf_clr_n}, 32'd3);

        // single true clause (x1 in every slot)
        write_entry(6'd0, ent1(1'b1, 1'b0, 4'd1));
        run(7'd1, 7, 1'b1, 1, 1'b0, "single");

        // reset while issuing
        @(negedge clk); num_entries = 7'd1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        check("mid_issue_en", 32'(enableClause), 32'd1);
        resetClause = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sat", 32'(sat), 32'd0);
        check("mid_rst_en", {30'd0, enableClause, enableCNF}, 32'd0);
        check("mid_rst_clr", {30'd0, clause_clr_n, cnf_clr_n}, 32'd0);
        check("mid_rst_lits", {2'd0, negCtrl, varPos}, 32'd0);
        @(negedge clk); resetClause = 1'b1;
        repeat (2) @(posedge clk);
        run(7'd1, 7, 1'b1, 1, 1'b0, "after_rst");

        // (x1) AND (x3): false
        write_entry(6'd0, ent1(1'b1, 1'b0, 4'd1));
        write_entry(6'd1, ent1(1'b1, 1'b0, 4'd3));
        run(7'd2, 10, 1'b0, 2, 1'b0, "two");

        // one clause over two beats: x0 | ~x5 = true
        write_entry(6'd0, ent1(1'b0, 1'b0, 4'd0));
        write_entry(6'd1, ent1(1'b1, 1'b1, 4'd5));
        run(7'd2, 8, 1'b1, 1, 1'b0, "multibeat");

        // (x0) AND (x1) AND (x2): first clause false
        write_entry(6'd0, ent1(1'b1, 1'b0, 4'd0));
        write_entry(6'd1, ent1(1'b1, 1'b0, 4'd1));
        write_entry(6'd2, ent1(1'b1, 1'b0, 4'd2));
`ifdef SAT_SEQ_EARLY_EXIT_EN
        run(7'd3, 7, 1'b0, 1, 1'b0, "three");
`else
        run(7'd3, 13, 1'b0, 3, 1'b0, "three");
`endif

        // empty CNF is SAT
        run(7'd0, 4, 1'b1, 0, 1'b0, "empty");

        // final entry lacks last bit: (x1) AND (x3 forced close) = false
        write_entry(6'd0, ent1(1'b1, 1'b0, 4'd1));
        write_entry(6'd1, ent1(1'b0, 1'b0, 4'd3));
        run(7'd2, 10, 1'b0, 2, 1'b0, "forced");

        // start and write while busy are ignored
        write_entry(6'd0, ent1(1'b1, 1'b0, 4'd2));
        run(7'd1, 7, 1'b1, 1, 1'b1, "busy_inject");
        run(7'd1, 7, 1'b1, 1, 1'b0, "mem_kept");

        check("no_overlap", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
